// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int TIMEOUT_DEF  = 255;
    localparam int WAIT_W       = 8;
    localparam int STALL_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } arb_state_t;

    // True on the busy cycle that would make the wait count reach the timeout.
    function automatic logic wait_expired(input logic [WAIT_W-1:0] cnt, input int unsigned timeout);
        return cnt == WAIT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_perf_counter.sv
// rtl/mem_port_arbiter_perf_counter.sv - free-running wrapping event counter
module perf_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int W = STALL_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single shared memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              if_stall,
    output logic              dm_stall,
    output logic              err,
    output logic [31:0]       stall_cnt
);

    arb_state_t        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic              err_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              expired;
    logic              done;

    assign wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    assign expired    = wait_expired(wait_cnt_q, TIMEOUT);
    // An ack on the expiring cycle still completes normally.
    assign done       = mem_ack | expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dm_req) begin
                        state_q     <= ST_DM_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        wait_cnt_q  <= '0;
                    end else if (if_req) begin
                        state_q    <= ST_IF_BUSY;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        wait_cnt_q <= '0;
                    end
                end
                ST_IF_BUSY: begin
                    if (done) begin
                        if_rdata_q <= mem_ack ? mem_rdata : '0;
                        if_ready_q <= 1'b1;
                        err_q      <= err_q | ~mem_ack;
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_DM_BUSY: begin
                    if (done) begin
                        if (!mem_ack) begin
                            dm_rdata_q <= '0;
                        end else if (!mem_we_q) begin
                            dm_rdata_q <= mem_rdata;
                        end
                        dm_ready_q <= 1'b1;
                        err_q      <= err_q | ~mem_ack;
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign dm_stall  = dm_req & ~dm_ready_q;

    perf_counter #(
        .W(32)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (if_stall | dm_stall),
        .count_o (stall_cnt)
    );

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 255, maximum wait cycles for mem_ack (1..255).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous and active-high.
- if_req  in  1  fetch-stage read request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word.
- if_ready  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  MEM-stage access request (MemRead or MemWrite).
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_ready  out  1  one-cycle data completion pulse.
- mem_req  out  1  request to the shared memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- if_stall  out  1  freeze PC and IF/ID.
- dm_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- err  out  1  sticky timeout flag.
- stall_cnt  out  32  count of cycles with dm_stall or if_stall high.

Function
REQ-003 FSM states SHALL be IDLE, IF_BUSY and DM_BUSY.
REQ-004 In IDLE, dm_req SHALL win over if_req; granting registers addr/we/wdata of the winner into the mem_* outputs and enters DM_BUSY or IF_BUSY on the next edge.
REQ-005 In IF_BUSY/DM_BUSY, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata SHALL hold stable until mem_ack or timeout.
REQ-006 IF_BUSY SHALL force mem_we = 0.
REQ-007 On mem_ack in IF_BUSY, mem_rdata SHALL be registered into if_rdata, if_ready SHALL pulse for exactly the next cycle, and the state SHALL return to IDLE.
REQ-008 On mem_ack in DM_BUSY for a read, mem_rdata SHALL be registered into dm_rdata and dm_ready SHALL pulse for one cycle; for a write, dm_ready SHALL pulse and dm_rdata SHALL stay unchanged.
REQ-009 Minimum latency SHALL be 3 cycles from request to ready pulse with a zero-wait memory (grant, ack, ready); no back-to-back grant, IDLE always spans one cycle between transactions.
REQ-010 mem_ack in IDLE SHALL be ignored.
REQ-011 if_stall SHALL be combinational: if_req & ~if_ready; dm_stall SHALL be dm_req & ~dm_ready.
REQ-012 A wait counter (8 bits) SHALL clear on grant and increment each busy cycle without mem_ack.
REQ-013 When the counter reaches TIMEOUT, the arbiter SHALL abandon the access: the granted requester's ready SHALL pulse, its rdata SHALL load 0, err SHALL set, and the state SHALL return to IDLE.
REQ-014 err SHALL stay 1 until rst.
REQ-015 mem_ack in the same cycle as the timeout SHALL take precedence, giving normal completion with no err.
REQ-016 stall_cnt SHALL increment by 1 on every cycle with (if_stall | dm_stall) and wrap from 2^32-1 to 0.
REQ-017 Requesters SHALL hold req and operands until their ready pulse; a req drop while busy SHALL NOT cancel the memory transaction.

Reset
REQ-018 On rst, the state SHALL go to IDLE and mem_req, mem_we, if_ready, dm_ready and err SHALL be 0.
REQ-019 On rst, mem_addr, mem_wdata, if_rdata, dm_rdata, the wait counter and stall_cnt SHALL be 0.
REQ-020 rst during a busy state SHALL drop mem_req on the next edge, and any later stray mem_ack SHALL be ignored per REQ-010.

Structure
REQ-021 The state encoding (2-bit, IDLE=0, IF_BUSY=1, DM_BUSY=2) and the default widths SHALL live in the shared pipeline package.
REQ-022 The stall_cnt wrapping counter SHALL be a sub-module named perf_counter; all other logic SHALL be flat.

Verification
REQ-023 Fetch only, ack 1 cycle after grant, mem_rdata = 0x8C220004 -> if_ready pulses 3 cycles after if_req, if_rdata = 0x8C220004, if_stall high for 3 cycles.
REQ-024 if_req and dm_req (read, addr 0x100) rise together -> DM_BUSY first, mem_addr = 0x100; fetch is granted after dm_ready plus one IDLE cycle.
REQ-025 dm write, addr 0x40, wdata 0xDEADBEEF, ack after 5 wait cycles -> mem_we = 1 and mem_wdata stable for all busy cycles, dm_ready pulses once, dm_rdata unchanged.
REQ-026 No mem_ack, TIMEOUT = 4 -> ready pulse with rdata = 0 after the 4th wait cycle, err = 1 until rst; ack on the timeout cycle -> no err.
REQ-027 rst asserted mid DM_BUSY, then mem_ack -> mem_req = 0 after the edge, no dm_ready pulse, stall_cnt = 0.
